// File: rtl/lut4_pkg.sv
// Shared types and constants for the programmable 4-input LUT pipeline.
package lut4_pkg;

    localparam int unsigned LUT_W = 16;

    typedef logic [LUT_W-1:0] lut_t;

    // F = (~A&~D) | ((A|B)&(~B|~C)), indexed by {a,b,c,d}
    localparam lut_t LUT_DEFAULT = 16'h3F75;

    function automatic logic [3:0] lut_index(input logic a, input logic b,
                                             input logic c, input logic d);
        return {a, b, c, d};
    endfunction

endpackage

// File: rtl/lut4_pipe_stage.sv
// One pipeline register slice: valid bit plus data, both advancing on en.
module lut4_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Data only loads with a valid beat so a bubble leaves the last result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/lut4_func_pipe.sv
// Programmable 4-input boolean function, bit-parallel over LANES, PIPE_STAGES deep.
// Define LUT4_FUNC_PIPE_TOGGLE_CNT_EN to build the output result-change counter.
module lut4_func_pipe
    import lut4_pkg::*;
#(
    parameter int unsigned LANES       = 8,
    parameter int unsigned PIPE_STAGES = 2,
    parameter lut_t        LUT_RST     = LUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [15:0]      cfg_lut,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_a,
    input  logic [LANES-1:0] in_b,
    input  logic [LANES-1:0] in_c,
    input  logic [LANES-1:0] in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] out_f,
    output logic [15:0]      toggle_cnt
);

    if (LANES < 1 || LANES > 32) begin : g_bad_lanes
        $fatal(1, "lut4_func_pipe: LANES must be in 1..32");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
        $fatal(1, "lut4_func_pipe: PIPE_STAGES must be in 1..4");
    end

    lut_t             lut_q;
    logic             adv;
    logic [LANES-1:0] eval;
    logic [PIPE_STAGES:0] stg_valid;
    logic [LANES-1:0]     stg_data [PIPE_STAGES+1];

    // Table write is independent of the handshake; same-cycle beats see the old table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_q <= LUT_RST;
        end else if (cfg_we) begin
            lut_q <= cfg_lut;
        end
    end

    always_comb begin
        eval = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            eval[i] = lut_q[lut_index(in_a[i], in_b[i], in_c[i], in_d[i])];
        end
    end

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    assign stg_valid[0] = in_valid;
    assign stg_data[0]  = eval;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        lut4_pipe_stage #(
            .W(LANES)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (adv),
            .in_valid (stg_valid[k]),
            .in_data  (stg_data[k]),
            .out_valid(stg_valid[k+1]),
            .out_data (stg_data[k+1])
        );
    end

    assign out_valid = stg_valid[PIPE_STAGES];
    assign out_f     = stg_data[PIPE_STAGES];

`ifdef LUT4_FUNC_PIPE_TOGGLE_CNT_EN
    logic [LANES-1:0] prev_q;
    logic [15:0]      cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else if (out_valid && out_ready) begin
            prev_q <= out_f;
            if (out_f != prev_q && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign toggle_cnt = cnt_q;
`else
    assign toggle_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lut4_func_pipe.sv
// Directed self-checking bench for lut4_func_pipe (depths 1, 2 and 4).
module tb_lut4_func_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [15:0] cfg_lut;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  in_a, in_b, in_c, in_d;

    logic        in_ready, out_valid;
    logic [7:0]  out_f;
    logic [15:0] toggle_cnt;

    logic        in_ready_p1, out_valid_p1, in_ready_p4, out_valid_p4;
    logic [7:0]  out_f_p1, out_f_p4;
    logic [15:0] toggle_cnt_p1, toggle_cnt_p4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lut4_func_pipe dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_lut(cfg_lut),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
        .toggle_cnt(toggle_cnt)
    );

    lut4_func_pipe #(.PIPE_STAGES(1)) dut_p1 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_lut(cfg_lut),
        .in_valid(in_valid), .in_ready(in_ready_p1),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid_p1), .out_ready(1'b1), .out_f(out_f_p1),
        .toggle_cnt(toggle_cnt_p1)
    );

    lut4_func_pipe #(.PIPE_STAGES(4)) dut_p4 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_lut(cfg_lut),
        .in_valid(in_valid), .in_ready(in_ready_p4),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid_p4), .out_ready(1'b1), .out_f(out_f_p4),
        .toggle_cnt(toggle_cnt_p4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane i gets {a,b,c,d} = (base + i) mod 16.
    task automatic beat_idx(input int base);
        logic [3:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 4'((base + i) & 15);
            in_a[i] = v[3];
            in_b[i] = v[2];
            in_c[i] = v[1];
            in_d[i] = v[0];
        end
        in_valid = 1'b1;
    endtask

    task automatic beat_d(input logic [7:0] d);
        in_a = 8'h00;
        in_b = 8'h00;
        in_c = 8'h00;
        in_d = d;
        in_valid = 1'b1;
    endtask

    task automatic program_lut(input logic [15:0] t);
        cfg_we  = 1'b1;
        cfg_lut = t;
        step();
        cfg_we  = 1'b0;
    endtask

    logic [7:0] vals [5];
    logic [7:0] got_q [$];
    logic       acc;
    int         idx;
    int         lat1, lat2, lat4;
    logic [15:0] exp_toggle;

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_lut = 16'h0000; in_valid = 1'b0;
        out_ready = 1'b1; in_a = 8'h00; in_b = 8'h00; in_c = 8'h00; in_d = 8'h00;
        repeat (3) step();

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_f", {24'd0, out_f}, 32'h00);
        check("rst_toggle", {16'd0, toggle_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // Default table over all 16 input combinations
        beat_idx(0); step();
        beat_idx(8); step();
        in_valid = 1'b0;
        check("def_lo_valid", {31'd0, out_valid}, 32'd1);
        check("def_lo_f", {24'd0, out_f}, 32'h75);
        step();
        check("def_hi_valid", {31'd0, out_valid}, 32'd1);
        check("def_hi_f", {24'd0, out_f}, 32'h3F);
        step();
        check("def_drained", {31'd0, out_valid}, 32'd0);

        // Reprogram in the same cycle as a beat: that beat uses the old table
        cfg_we = 1'b1; cfg_lut = 16'h8000;
        in_a = 8'hFF; in_b = 8'hFF; in_c = 8'hFF; in_d = 8'hFF; in_valid = 1'b1;
        step();
        cfg_we = 1'b0;
        step();
        in_valid = 1'b0;
        check("cfg_old_f", {24'd0, out_f}, 32'h00);
        step();
        check("cfg_new_valid", {31'd0, out_valid}, 32'd1);
        check("cfg_new_f", {24'd0, out_f}, 32'hFF);
        repeat (2) step();

        // Backpressure: f = d, five beats, three stalled cycles
        program_lut(16'hAAAA);
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        idx = 0; beat_d(vals[0]); step();
        idx = 1; beat_d(vals[1]); step();
        idx = 2; beat_d(vals[2]);
        out_ready = 1'b0;
        #1;
        check("bp_in_ready_lo", {31'd0, in_ready}, 32'd0);
        check("bp_head_f", {24'd0, out_f}, 32'h11);
        for (int s = 0; s < 3; s++) begin
            step();
            check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
            check("bp_stall_f", {24'd0, out_f}, 32'h11);
            check("bp_stall_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        got_q.delete();
        for (int k = 0; k < 12; k++) begin
            if (out_valid) got_q.push_back(out_f);
            acc = in_valid & in_ready;
            step();
            if (acc) begin
                idx++;
                if (idx < 5) beat_d(vals[idx]);
                else in_valid = 1'b0;
            end
        end
        check("bp_count", got_q.size(), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < got_q.size()) check("bp_order", {24'd0, got_q[k]}, {24'd0, vals[k]});
        end

        // Mid-stream reset with two beats in flight
        beat_idx(0); step();
        beat_idx(8); step();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_out_f", {24'd0, out_f}, 32'h00);
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("mrst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        beat_idx(0); step();
        in_valid = 1'b0;
        step();
        check("mrst_lut_valid", {31'd0, out_valid}, 32'd1);
        check("mrst_lut_default", {24'd0, out_f}, 32'h75);
        repeat (2) step();

        // Latency at depths 1, 2, 4
        beat_idx(8); step();
        in_valid = 1'b0;
        lat1 = 0; lat2 = 0; lat4 = 0;
        for (int k = 1; k <= 8; k++) begin
            if (out_valid_p1 && lat1 == 0) lat1 = k;
            if (out_valid    && lat2 == 0) lat2 = k;
            if (out_valid_p4 && lat4 == 0) lat4 = k;
            step();
        end
        check("lat_p1", lat1, 32'd1);
        check("lat_p2", lat2, 32'd2);
        check("lat_p4", lat4, 32'd4);
        check("lat_p4_f", {24'd0, out_f_p4}, 32'h3F);
        check("lat_p1_f", {24'd0, out_f_p1}, 32'h3F);

        // Toggle counter over results 00, 00, F5, F5, 3F
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        program_lut(16'hAAAA);
        vals = '{8'h00, 8'h00, 8'hF5, 8'hF5, 8'h3F};
        for (int k = 0; k < 5; k++) begin
            beat_d(vals[k]);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
`ifdef LUT4_FUNC_PIPE_TOGGLE_CNT_EN
        exp_toggle = 16'd2;
`else
        exp_toggle = 16'd0;
`endif
        check("toggle_cnt", {16'd0, toggle_cnt}, {16'd0, exp_toggle});
        check("toggle_last_f", {24'd0, out_f}, 32'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
